// File: rtl/kmeans_mem_arbiter.sv
// kmeans_mem_arbiter
// ------------------
// Shares the single-port k-means point SRAM between three requesters:
// the point loader (writes), the assignment scanner (reads) and the
// debug/readback port (reads). Ownership rotates round-robin
// (loader -> scanner -> debug). An owner keeps the port for up to MAX_BURST
// consecutive transfers while anyone else is waiting. If nobody else is
// waiting, the owner keeps the port indefinitely. Every release costs one
// IDLE cycle.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   ld_req/ld_addr/ld_wdata      loader write request, address, data
//   ld_gnt                       loader owns the port
//   sc_req/sc_addr, sc_gnt       scanner read request/address, grant
//   sc_rvalid                    scanner read data valid on rdata
//   db_req/db_addr, db_gnt       debug read request/address, grant
//   db_rvalid                    debug read data valid on rdata
//   rdata                        shared read data, qualified by *_rvalid
//   busy                         port granted or a read still in flight
//   mem_a/mem_di/mem_web         registered SRAM macro pins
//   mem_do                       macro read data, valid one cycle after
//                                the macro samples its pins
module kmeans_mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic              sc_gnt,
  output logic              sc_rvalid,
  input  logic              db_req,
  input  logic [ADDR_W-1:0] db_addr,
  output logic              db_gnt,
  output logic              db_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_web,
  input  logic [DATA_W-1:0] mem_do
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [1:0] OWN_LD = 2'd0;
  localparam logic [1:0] OWN_SC = 2'd1;
  localparam logic [1:0] OWN_DB = 2'd2;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg;
  logic [1:0]        owner_reg;
  logic [1:0]        rr_ptr_reg;
  logic [CNT_W-1:0]  burst_cnt_reg;
  logic [2:0]        gnt_reg;        // one-hot {db, sc, ld}
  logic [2:0]        sc_tag_reg;     // read tag pipeline, stage 0 = newest
  logic [2:0]        db_tag_reg;
  logic [DATA_W-1:0] rdata_reg;

  // Bit 3 is a constant zero so any 2-bit owner index stays in range.
  logic [3:0]        req_vec;
  logic [1:0]        cand [3];
  logic [1:0]        pick;
  logic [3:0]        owner_onehot;
  logic              owner_req;
  logic              other_req;
  logic              xfer;
  logic [CNT_W-1:0]  burst_inc;
  logic [ADDR_W-1:0] addr_mux;

  function automatic logic [1:0] rr_next(input logic [1:0] o);
    return (o == OWN_DB) ? OWN_LD : o + 2'd1;
  endfunction

  assign req_vec = {1'b0, db_req, sc_req, ld_req};

  // Candidate owners in round-robin order starting at rr_ptr.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cand
      if (gi == 0) begin : g_first
        assign cand[gi] = rr_ptr_reg;
      end else begin : g_rest
        assign cand[gi] = rr_next(cand[gi-1]);
      end
    end
  endgenerate

  // Later assignments override earlier ones, so the first requesting
  // candidate in rotation order wins.
  always_comb begin
    pick = cand[2];
    if (req_vec[cand[1]]) pick = cand[1];
    if (req_vec[cand[0]]) pick = cand[0];
  end

  assign owner_onehot = 4'b0001 << owner_reg;
  assign owner_req    = req_vec[owner_reg];
  assign other_req    = |(req_vec & ~owner_onehot);
  assign xfer         = (state_reg == GRANT) && owner_req;
  assign burst_inc    = burst_cnt_reg + CNT_W'(1);

  always_comb begin
    case (owner_reg)
      OWN_LD:  addr_mux = ld_addr;
      OWN_SC:  addr_mux = sc_addr;
      default: addr_mux = db_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_LD;
      rr_ptr_reg    <= OWN_LD;
      burst_cnt_reg <= '0;
      gnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            state_reg     <= GRANT;
            owner_reg     <= pick;
            gnt_reg       <= 3'(4'b0001 << pick);
            burst_cnt_reg <= '0;
          end
        end
        GRANT: begin
          // Release on an idle owner, or on a full burst while someone waits.
          // A full burst with nobody waiting restarts the count instead.
          if (!owner_req || (burst_inc == CNT_W'(MAX_BURST) && other_req)) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            rr_ptr_reg    <= rr_next(owner_reg);
            burst_cnt_reg <= '0;
          end else if (burst_inc == CNT_W'(MAX_BURST)) begin
            burst_cnt_reg <= '0;
          end else begin
            burst_cnt_reg <= burst_inc;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Macro pins: the address and data hold between transfers. Only the write
  // strobe returns to its inactive level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_a   <= '0;
      mem_di  <= '0;
      mem_web <= 1'b1;
    end else if (xfer) begin
      mem_a   <= addr_mux;
      mem_web <= (owner_reg != OWN_LD);
      if (owner_reg == OWN_LD) mem_di <= ld_wdata;
    end else begin
      mem_web <= 1'b1;
    end
  end

  // Tag pipeline: stage 0 while the macro samples, stage 1 while mem_do is
  // valid (captured into rdata), stage 2 while rdata is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_tag_reg <= '0;
      db_tag_reg <= '0;
      rdata_reg  <= '0;
    end else begin
      sc_tag_reg <= {sc_tag_reg[1:0], xfer && (owner_reg == OWN_SC)};
      db_tag_reg <= {db_tag_reg[1:0], xfer && (owner_reg == OWN_DB)};
      if (sc_tag_reg[1] || db_tag_reg[1]) rdata_reg <= mem_do;
    end
  end

  assign ld_gnt    = gnt_reg[0];
  assign sc_gnt    = gnt_reg[1];
  assign db_gnt    = gnt_reg[2];
  assign sc_rvalid = sc_tag_reg[2];
  assign db_rvalid = db_tag_reg[2];
  assign rdata     = rdata_reg;
  assign busy      = (state_reg == GRANT) || (|sc_tag_reg) || (|db_tag_reg);

endmodule
